// File: rtl/traffic_pkg.sv
// Shared constants and types for the intersection timing blocks.
package traffic_pkg;

  localparam int NUM_SLOTS = 3;
  localparam int DATA_W    = 4;

  // Interval register addresses on the time-parameter write port.
  localparam logic [1:0] BASE_ADD = 2'd0;
  localparam logic [1:0] EXT_ADD  = 2'd1;
  localparam logic [1:0] YEL_ADD  = 2'd2;
  localparam logic [1:0] ILL_SEL  = 2'd3;

  // Values substituted when a programming request carries 0 seconds.
  localparam logic [DATA_W-1:0] BASE_DEF = 4'd6;
  localparam logic [DATA_W-1:0] EXTD_DEF = 4'd3;
  localparam logic [DATA_W-1:0] YELL_DEF = 4'd2;

  typedef enum logic [1:0] {IDLE, HOLD, WRITE, RESTART} seq_state_e;

  // One synchronized programming request.
  typedef struct packed {
    logic              req;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } prog_cmd_t;

  // A zero interval is never useful; fall back to the slot default.
  function automatic logic [DATA_W-1:0] subst_default(input logic [DATA_W-1:0] d,
                                                      input logic [DATA_W-1:0] dflt);
    return (d == '0) ? dflt : d;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Request / write-port / FSM-control bundle of the programming sequencer.
interface prog_sequencer_if;
  import traffic_pkg::*;

  logic              tick;
  logic              prog_req;
  logic [1:0]        prog_sel;
  logic [DATA_W-1:0] prog_data;
  logic              safe_point;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              fsm_hold;
  logic              fsm_restart;
  logic              prog_busy;
  logic              prog_err;

  modport master (
    output tick, prog_req, prog_sel, prog_data, safe_point,
    input  cfg_we, cfg_addr, cfg_wdata, fsm_hold, fsm_restart, prog_busy, prog_err
  );

  modport slave (
    input  tick, prog_req, prog_sel, prog_data, safe_point,
    output cfg_we, cfg_addr, cfg_wdata, fsm_hold, fsm_restart, prog_busy, prog_err
  );

endinterface

// File: rtl/prog_shadow_regs.sv
// Three pending-interval slots with capture-over-clear priority and a
// lowest-valid-index search starting at a caller-supplied index.
module prog_shadow_regs
  import traffic_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_DEFAULT = BASE_DEF,
  parameter logic [DATA_W-1:0] EXTD_DEFAULT = EXTD_DEF,
  parameter logic [DATA_W-1:0] YELL_DEFAULT = YELL_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  prog_cmd_t            cmd,
  input  logic                 clr_en,
  input  logic [1:0]           clr_idx,
  input  logic [1:0]           start,
  output logic [NUM_SLOTS-1:0] vld,
  output logic                 hit,
  output logic [1:0]           idx,
  output logic [DATA_W-1:0]    rdata,
  output logic                 more
);

  logic [NUM_SLOTS-1:0][DATA_W-1:0] data_q;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] dflt;
  logic [NUM_SLOTS-1:0]             vld_q;

  // Per-slot default table indexed by write address.
  always_comb begin
    dflt           = '0;
    dflt[BASE_ADD] = BASE_DEFAULT;
    dflt[EXT_ADD]  = EXTD_DEFAULT;
    dflt[YEL_ADD]  = YELL_DEFAULT;
  end

  // Capture wins over a same-cycle clear so a fresh value is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cmd.req && cmd.sel == 2'(i)) begin
          vld_q[i]  <= 1'b1;
          data_q[i] <= subst_default(cmd.data, dflt[i]);
        end else if (clr_en && clr_idx == 2'(i)) begin
          vld_q[i]  <= 1'b0;
        end
      end
    end
  end

  // Lowest valid slot at or above start (descending scan keeps the lowest).
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (vld_q[i] && 2'(i) >= start) begin
        hit = 1'b1;
        idx = 2'(i);
      end
    end
  end

  // Any valid slot above the selected one still to go in this pass.
  always_comb begin
    more = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (vld_q[i] && 2'(i) > idx) more = 1'b1;
    end
  end

  assign rdata = data_q[idx];
  assign vld   = vld_q;

endmodule

// File: rtl/prog_sequencer.sv
// Buffers interval reprogramming requests, parks the light FSM at a safe
// boundary (or forces after a timeout), drains the slots to the
// time-parameter registers and restarts the FSM cycle.
module prog_sequencer
  import traffic_pkg::*;
#(
  parameter int                MAX_WAIT_TICKS = 10,
  parameter logic [DATA_W-1:0] BASE_DEFAULT   = BASE_DEF,
  parameter logic [DATA_W-1:0] EXTD_DEFAULT   = EXTD_DEF,
  parameter logic [DATA_W-1:0] YELL_DEFAULT   = YELL_DEF
) (
  input  logic             clk,
  input  logic             Reset_n,
  prog_sequencer_if.slave  bus
);

  localparam int               CNT_W   = $clog2(MAX_WAIT_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT_TICKS);

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           wr_ptr_q;
  logic                 err_q;
  logic                 timeout;
  prog_cmd_t            cmd;
  logic                 legal_req, illegal_req;
  logic [NUM_SLOTS-1:0] vld;
  logic                 hit, more, write_en;
  logic [1:0]           idx;
  logic [DATA_W-1:0]    rdata;

  assign cmd         = '{req: bus.prog_req, sel: bus.prog_sel, data: bus.prog_data};
  assign legal_req   = bus.prog_req && (bus.prog_sel != ILL_SEL);
  assign illegal_req = bus.prog_req && (bus.prog_sel == ILL_SEL);
  assign write_en    = (state_q == WRITE) && hit;

  prog_shadow_regs #(
    .BASE_DEFAULT (BASE_DEFAULT),
    .EXTD_DEFAULT (EXTD_DEFAULT),
    .YELL_DEFAULT (YELL_DEFAULT)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (Reset_n),
    .cmd     (cmd),
    .clr_en  (write_en),
    .clr_idx (idx),
    .start   (wr_ptr_q),
    .vld     (vld),
    .hit     (hit),
    .idx     (idx),
    .rdata   (rdata),
    .more    (more)
  );

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; a request arriving while idle counts immediately so HOLD
  // starts the cycle after the strobe.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:    if (|vld || legal_req) state_d = HOLD;
      HOLD: begin
        if (bus.safe_point) begin
          state_d = WRITE;
        end else if (cnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE:   if (!hit || !more) state_d = RESTART;
      RESTART: state_d = (|vld || legal_req) ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tick counter: zero outside HOLD, so it is clear on every HOLD entry.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)                        cnt_q <= '0;
    else if (state_q != HOLD)            cnt_q <= '0;
    else if (bus.tick && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
  end

  // Pass pointer: slots below it were already written in this WRITE pass.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)             wr_ptr_q <= '0;
    else if (state_q != WRITE) wr_ptr_q <= '0;
    else if (write_en)         wr_ptr_q <= idx + 2'd1;
  end

  // Illegal-target error pulse, aligned with slot-valid timing.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= illegal_req;
  end

  assign bus.cfg_we      = write_en;
  assign bus.cfg_addr    = write_en ? idx : 2'd0;
  assign bus.cfg_wdata   = write_en ? rdata : '0;
  assign bus.fsm_hold    = (state_q != IDLE);
  assign bus.fsm_restart = (state_q == RESTART);
  assign bus.prog_busy   = (state_q != IDLE) || (|vld);
  assign bus.prog_err    = err_q || timeout;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a slot/queue level reference model.
module tb_prog_sequencer;
  import traffic_pkg::*;

  localparam int         MAXW   = 10;
  localparam logic [3:0] D_BASE = 4'd6;
  localparam logic [3:0] D_EXT  = 4'd3;
  localparam logic [3:0] D_YEL  = 4'd2;

  logic clk, Reset_n;
  prog_sequencer_if bus();

  prog_sequencer #(
    .MAX_WAIT_TICKS (MAXW),
    .BASE_DEFAULT   (D_BASE),
    .EXTD_DEFAULT   (D_EXT),
    .YELL_DEFAULT   (D_YEL)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, last_c = 0;
  int w_addr[$], w_data[$], w_cyc[$], err_cyc[$], rs_cyc[$];
  int hold_n = 0, busy_n = 0;

  // Reference model: pending slots plus an explicit queue of writes.
  logic [3:0] m_dat[3];
  bit         m_vld[3];
  bit         m_active, m_restart, m_err_q;
  int         m_wait;
  int         wq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [3:0] dflt(input logic [1:0] s);
    case (s)
      2'd0:    return D_BASE;
      2'd1:    return D_EXT;
      default: return D_YEL;
    endcase
  endfunction

  // Per-cycle compare against the model, then advance the model by one edge.
  initial begin
    m_active = 0; m_restart = 0; m_err_q = 0; m_wait = 0;
    for (int i = 0; i < 3; i++) begin m_vld[i] = 0; m_dat[i] = '0; end
    forever begin
      bit e_we, e_hold, e_rs, e_busy, e_err, wt, anyv;
      int e_addr, e_wdata, a;
      @(negedge clk);
      cyc++;
      anyv = m_vld[0] | m_vld[1] | m_vld[2];
      e_we = (wq.size() > 0);
      wt   = m_active && !e_we && !m_restart;
      if (!Reset_n) begin
        e_we = 0; e_addr = 0; e_wdata = 0; e_hold = 0; e_rs = 0; e_busy = 0; e_err = 0;
      end else begin
        e_addr  = e_we ? wq[0] : 0;
        e_wdata = e_we ? int'(m_dat[wq[0]]) : 0;
        e_hold  = m_active;
        e_rs    = m_restart;
        e_busy  = m_active || anyv;
        e_err   = m_err_q || (wt && m_wait == MAXW && !bus.safe_point);
      end
      chk("cfg_we",      bus.cfg_we,      e_we);
      chk("cfg_addr",    bus.cfg_addr,    e_addr);
      chk("cfg_wdata",   bus.cfg_wdata,   e_wdata);
      chk("fsm_hold",    bus.fsm_hold,    e_hold);
      chk("fsm_restart", bus.fsm_restart, e_rs);
      chk("prog_busy",   bus.prog_busy,   e_busy);
      chk("prog_err",    bus.prog_err,    e_err);
      if (Reset_n) begin
        if (bus.cfg_we) begin
          w_addr.push_back(bus.cfg_addr); w_data.push_back(bus.cfg_wdata); w_cyc.push_back(cyc);
        end
        if (bus.prog_err)    err_cyc.push_back(cyc);
        if (bus.fsm_restart) rs_cyc.push_back(cyc);
        if (bus.fsm_hold)    hold_n++;
        if (bus.prog_busy)   busy_n++;
      end
      // model step for the coming edge
      if (!Reset_n) begin
        for (int i = 0; i < 3; i++) begin m_vld[i] = 0; m_dat[i] = '0; end
        m_active = 0; m_restart = 0; m_err_q = 0; m_wait = 0; wq.delete();
      end else begin
        bit rs;
        rs = m_restart;
        if (e_we) begin a = wq.pop_front(); m_vld[a] = 0; end
        if (bus.prog_req && bus.prog_sel != 2'd3) begin
          m_vld[bus.prog_sel] = 1;
          m_dat[bus.prog_sel] = (bus.prog_data == 0) ? dflt(bus.prog_sel) : bus.prog_data;
        end
        m_err_q = bus.prog_req && bus.prog_sel == 2'd3;
        anyv = m_vld[0] | m_vld[1] | m_vld[2];
        if (e_we) begin
          if (wq.size() == 0) m_restart = 1;
        end else if (rs) begin
          m_restart = 0;
          if (anyv) m_wait = 0; else m_active = 0;
        end else if (wt) begin
          if (bus.safe_point || m_wait == MAXW) begin
            for (int i = 0; i < 3; i++) if (m_vld[i]) wq.push_back(i);
          end else if (bus.tick && m_wait < MAXW) m_wait++;
        end else if (anyv) begin
          m_active = 1; m_wait = 0;
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [1:0] s, input logic [3:0] d,
                       input logic sp, input logic tk);
    @(posedge clk); #1;
    bus.prog_req = r; bus.prog_sel = s; bus.prog_data = d;
    bus.safe_point = sp; bus.tick = tk;
    last_c = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete(); err_cyc.delete(); rs_cyc.delete();
    hold_n = 0; busy_n = 0;
  endtask

  initial begin
    int sc, tc, c6;
    Reset_n = 1'b0;
    bus.prog_req = 0; bus.prog_sel = 0; bus.prog_data = 0; bus.safe_point = 0; bus.tick = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   bus.cfg_we,    0);
    chk("rst_hold", bus.fsm_hold,  0);
    chk("rst_busy", bus.prog_busy, 0);
    Reset_n = 1'b1;
    idle(2);

    // Single base write after a 3-cycle wait for the safe point.
    clear_logs();
    drive(1, 2'd0, 4'd9, 0, 0);
    idle(2);
    drive(0, 2'd0, 4'd0, 1, 0); sc = last_c;
    idle(4);
    chk("t2_nwr",   w_addr.size(), 1);
    chk("t2_addr",  qget(w_addr, 0), 0);
    chk("t2_data",  qget(w_data, 0), 9);
    chk("t2_wcyc",  qget(w_cyc, 0), sc + 1);
    chk("t2_rcyc",  qget(rs_cyc, 0), sc + 2);
    chk("t2_hold",  hold_n, 5);

    // Overwrite of a pending slot; one pass writes ext then yellow.
    clear_logs();
    drive(1, 2'd2, 4'd0, 0, 0);
    drive(1, 2'd1, 4'd5, 0, 0);
    drive(1, 2'd2, 4'd4, 0, 0);
    drive(0, 2'd0, 4'd0, 1, 0); sc = last_c;
    idle(5);
    chk("t3_nwr",   w_addr.size(), 2);
    chk("t3_a0",    qget(w_addr, 0), 1);
    chk("t3_d0",    qget(w_data, 0), 5);
    chk("t3_a1",    qget(w_addr, 1), 2);
    chk("t3_d1",    qget(w_data, 1), 4);
    chk("t3_c1",    qget(w_cyc, 1), sc + 2);
    chk("t3_nrs",   rs_cyc.size(), 1);
    chk("t3_rcyc",  qget(rs_cyc, 0), sc + 3);

    // Zero data on every slot takes the defaults.
    clear_logs();
    drive(1, 2'd0, 4'd0, 0, 0);
    drive(1, 2'd1, 4'd0, 0, 0);
    drive(1, 2'd2, 4'd0, 1, 0);
    idle(6);
    chk("t3b_nwr",  w_addr.size(), 3);
    chk("t3b_d0",   qget(w_data, 0), 6);
    chk("t3b_d1",   qget(w_data, 1), 3);
    chk("t3b_d2",   qget(w_data, 2), 2);

    // Illegal target.
    clear_logs();
    drive(1, 2'd3, 4'd5, 0, 0);
    idle(3);
    chk("t4_nerr",  err_cyc.size(), 1);
    chk("t4_busy",  busy_n, 0);
    chk("t4_nwr",   w_addr.size(), 0);

    // Safe point never arrives: timeout after MAXW ticks forces the write.
    clear_logs();
    drive(1, 2'd1, 4'd7, 0, 0);
    tc = 0;
    for (int i = 0; i < MAXW; i++) begin
      drive(0, 2'd0, 4'd0, 0, 1); tc = last_c;
      idle(1);
    end
    idle(5);
    chk("t5_nerr",  err_cyc.size(), 1);
    chk("t5_ecyc",  qget(err_cyc, 0), tc + 1);
    chk("t5_nwr",   w_addr.size(), 1);
    chk("t5_addr",  qget(w_addr, 0), 1);
    chk("t5_data",  qget(w_data, 0), 7);
    chk("t5_wcyc",  qget(w_cyc, 0), tc + 2);
    chk("t5_nrs",   rs_cyc.size(), 1);

    // Request to the slot being written: captured, rewritten next pass.
    clear_logs();
    drive(1, 2'd0, 4'd3, 0, 0); c6 = last_c;
    drive(0, 2'd0, 4'd0, 1, 0);
    drive(1, 2'd0, 4'd12, 0, 0);
    idle(2);
    drive(0, 2'd0, 4'd0, 1, 0);
    idle(4);
    chk("t6_nwr",   w_addr.size(), 2);
    chk("t6_d0",    qget(w_data, 0), 3);
    chk("t6_d1",    qget(w_data, 1), 12);
    chk("t6_a1",    qget(w_addr, 1), 0);
    chk("t6_nrs",   rs_cyc.size(), 2);
    chk("t6_wcyc",  qget(w_cyc, 1), c6 + 6);
    chk("t6_hold",  hold_n, 7);

    // Reset in the middle of a two-slot write pass.
    clear_logs();
    drive(1, 2'd0, 4'd5, 0, 0);
    drive(1, 2'd1, 4'd6, 0, 0);
    drive(0, 2'd0, 4'd0, 1, 0);
    idle(1);
    @(posedge clk); #1;
    Reset_n = 1'b0;
    #1;
    chk("t1_rst_we",   bus.cfg_we,    0);
    chk("t1_rst_hold", bus.fsm_hold,  0);
    chk("t1_rst_busy", bus.prog_busy, 0);
    chk("t1_nwr",      w_addr.size(), 1);
    chk("t1_d0",       qget(w_data, 0), 5);
    repeat (2) @(posedge clk);
    #1 Reset_n = 1'b1;
    clear_logs();
    idle(5);
    chk("t1_post_busy", busy_n, 0);
    chk("t1_post_we",   w_addr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
